// File: rtl/pc_lut_pkg.sv
// Shared types and constants for the branch-offset table loader.
// Record framing tags, FSM state encoding and default table geometry.
package pc_lut_pkg;

    localparam int D = 12;
    localparam int N = 64;

    localparam logic [1:0] TAG_REC = 2'b10;
    localparam logic [1:0] TAG_END = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HI     = 2'd1,
        LO     = 2'd2,
        SEALED = 2'd3
    } state_t;

endpackage

// File: rtl/pc_lut_loader_if.sv
// Byte-stream valid/ready channel feeding the table loader.
// The producer drives data/valid; the loader answers with ready.
interface pc_lut_loader_if;

    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/pc_lut_ram.sv
// Flop-based offset table: one synchronous write port,
// one combinational read port, cleared by async reset.
module pc_lut_ram #(
    parameter int D = 12,
    parameter int N = 64
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                we,
    input  logic [5:0]          wr_addr,
    input  logic [D-1:0]        wr_data,
    input  logic [5:0]          rd_addr,
    output logic signed [D-1:0] rd_data
);

    logic [D-1:0] mem [N];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = $signed(mem[rd_addr]);

endmodule

// File: rtl/pc_lut_loader.sv
// Parses 3-byte records from the byte stream into the offset table.
// Framing errors are sticky; an end tag seals the table until reset.
module pc_lut_loader #(
    parameter int D = pc_lut_pkg::D,
    parameter int N = pc_lut_pkg::N
) (
    input  logic                clk,
    input  logic                reset_n,
    pc_lut_loader_if.slave      bus,
    input  logic [5:0]          rd_addr,
    output logic signed [D-1:0] rd_target,
    output logic                loaded,
    output logic                err,
    output logic [6:0]          wr_count
);

    import pc_lut_pkg::*;

    state_t     state;
    logic [5:0] idx;
    logic [3:0] off_hi;
    logic       ready;
    logic       fire;
    logic       we;
    logic [1:0] tag;
    logic [D-1:0] wr_data;

    assign bus.in_ready = ready;
    assign fire    = bus.in_valid & ready;
    assign tag     = bus.in_data[7:6];
    assign we      = fire && (state == LO);
    assign wr_data = D'($signed({off_hi, bus.in_data}));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            idx      <= '0;
            off_hi   <= '0;
            ready    <= 1'b1;
            loaded   <= 1'b0;
            err      <= 1'b0;
            wr_count <= '0;
        end else if (fire) begin
            unique case (state)
                IDLE: begin
                    unique case (1'b1)
                        (tag == TAG_REC): begin
                            idx   <= bus.in_data[5:0];
                            state <= HI;
                        end
                        (tag == TAG_END): begin
                            state  <= SEALED;
                            ready  <= 1'b0;
                            loaded <= 1'b1;
                        end
                        default: err <= 1'b1;
                    endcase
                end
                HI: begin
                    // Only a 12-bit offset fits; a set upper nibble breaks framing.
                    if (bus.in_data[7:4] != 4'h0) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        off_hi <= bus.in_data[3:0];
                        state  <= LO;
                    end
                end
                LO: begin
                    state <= IDLE;
                    if (wr_count != 7'd127) begin
                        wr_count <= wr_count + 7'd1;
                    end
                end
                default: state <= SEALED;
            endcase
        end
    end

    pc_lut_ram #(
        .D (D),
        .N (N)
    ) u_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (we),
        .wr_addr (idx),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_target)
    );

endmodule

// File: tb/tb_pc_lut_loader.sv
// Directed-vector bench for pc_lut_loader.
// Expected values are hand-computed from the record format.
module tb_pc_lut_loader;

    logic               clk;
    logic               reset_n;
    logic [5:0]         rd_addr;
    logic signed [11:0] rd_target;
    logic               loaded;
    logic               err;
    logic [6:0]         wr_count;

    int checks;
    int errors;

    pc_lut_loader_if bus ();

    pc_lut_loader dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus.slave),
        .rd_addr   (rd_addr),
        .rd_target (rd_target),
        .loaded    (loaded),
        .err       (err),
        .wr_count  (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [5:0] a, input string tag, input int exp);
        rd_addr = a;
        #1;
        chk(tag, int'(rd_target), exp);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
        idle(1);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset_n      = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        rd_addr      = 6'd0;
        idle(2);
        reset_n = 1'b1;
        idle(1);

        chk("rst_ready", int'(bus.in_ready), 1);
        chk("rst_loaded", int'(loaded), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_count", int'(wr_count), 0);
        rd(6'd0, "rst_e0", 0);

        send(8'h80); send(8'h00); send(8'h0B);
        rd(6'd0, "e0_11", 11);
        chk("count1", int'(wr_count), 1);

        send(8'h91);
        idle(7);
        chk("gap_ready", int'(bus.in_ready), 1);
        send(8'h0F);
        idle(5);
        bus.in_data  = 8'h71;
        bus.in_valid = 1'b1;
        rd(6'd17, "same_cycle_old", 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        rd(6'd17, "e17_neg", -143);
        rd(6'd18, "e18_zero", 0);
        chk("count2", int'(wr_count), 2);
        chk("no_err_yet", int'(err), 0);

        send(8'h45);
        chk("bad_tag_err", int'(err), 1);
        send(8'h85); send(8'h01); send(8'h23);
        rd(6'd5, "e5_after_err", 291);
        chk("count3", int'(wr_count), 3);
        send(8'h85); send(8'h0F); send(8'hFF);
        rd(6'd5, "e5_rewrite", -1);
        chk("count4", int'(wr_count), 4);
        chk("err_sticky", int'(err), 1);

        send(8'h83); send(8'h00);
        reset_n = 1'b0;
        #1;
        rd(6'd0, "async_e0", 0);
        rd(6'd17, "async_e17", 0);
        chk("async_count", int'(wr_count), 0);
        chk("async_err", int'(err), 0);
        chk("async_loaded", int'(loaded), 0);
        idle(1);
        reset_n = 1'b1;
        idle(1);
        chk("rel_ready", int'(bus.in_ready), 1);
        send(8'h05);
        chk("rel_b0_err", int'(err), 1);
        rd(6'd3, "no_partial_e3", 0);
        chk("rel_count", int'(wr_count), 0);

        do_reset();
        send(8'h80); send(8'h00); send(8'h0B);
        send(8'h82); send(8'h00); send(8'h07);
        chk("pre_hi_err", int'(err), 0);
        send(8'h82); send(8'h10);
        chk("hi_err", int'(err), 1);
        rd(6'd2, "e2_unchanged", 7);
        send(8'h84); send(8'h00); send(8'h09);
        rd(6'd4, "e4_resync", 9);
        chk("count_b", int'(wr_count), 3);

        send(8'hC0);
        chk("seal_loaded", int'(loaded), 1);
        chk("seal_ready", int'(bus.in_ready), 0);
        send(8'h80); send(8'h00); send(8'h05);
        idle(2);
        rd(6'd0, "seal_e0", 11);
        chk("seal_count", int'(wr_count), 3);
        chk("seal_stays", int'(loaded), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_lut_loader.md
PC_LUT_LOADER -- requirements
Module: pc_lut_loader

Interface
REQ-001 Parameter D, default 12, is the width of a stored branch offset.
REQ-002 Parameter N, default 64, is the number of table entries; the index is 6 bits wide.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port in_data, input, 8 bits: the load byte stream.
REQ-006 Port in_valid, input, 1 bit: in_data holds a byte.
REQ-007 Port in_ready, output, 1 bit: the block accepts a byte this cycle.
REQ-008 Port rd_addr, input, 6 bits: table lookup index.
REQ-009 Port rd_target, output, D bits: signed relative PC offset stored at rd_addr; combinational.
REQ-010 Port loaded, output, 1 bit: the table is sealed (load complete).
REQ-011 Port err, output, 1 bit: sticky flag for a framing error.
REQ-012 Port wr_count, output, 7 bits: number of records written since reset, saturating at 127.

Function
REQ-013 A byte transfers only in a cycle where in_valid and in_ready are both 1.
REQ-014 Each record is 3 bytes, sent in this order:
- B0 = {tag[1:0], idx[5:0]}
- B1 = {4'b0000, off[11:8]}
- B2 = off[7:0]
REQ-015 The FSM states are IDLE, HI, LO and SEALED; the reset state is IDLE.
REQ-016 IDLE on an accepted B0:
- tag 2'b10: latch idx and go to HI.
- tag 2'b11: go to SEALED.
- tag 2'b00 or 2'b01: set err and stay in IDLE.
REQ-017 HI on an accepted byte:
- Upper nibble nonzero: set err, discard the record, return to IDLE.
- Otherwise: latch off[11:8] and go to LO.
REQ-018 LO on an accepted byte: write {off[11:8], byte} to entry idx at that clock edge, increment wr_count, return to IDLE.
REQ-019 in_ready shall be 1 in IDLE, HI and LO, and 0 in SEALED.
REQ-020 In SEALED, loaded shall be 1 and in_valid shall be ignored; only reset exits SEALED.
REQ-021 A read of the entry written in the same cycle shall return the old value; the new value is visible from the next cycle.
REQ-022 Rewriting an index shall overwrite it; wr_count still increments.
REQ-023 in_valid deasserting mid-record shall hold the FSM state indefinitely, with no timeout.
REQ-024 Once set, err shall remain 1 until reset and shall not block later records.
REQ-025 Entries never written read 0, meaning hold PC.

Reset
REQ-026 reset_n=0 shall immediately, with no clock edge, force:
- state to IDLE
- all N entries to 0
- loaded=0, err=0, wr_count=0
- in_ready=1 once reset releases.
REQ-027 Reset asserted mid-record shall discard the partial record; no partial write shall occur.
REQ-028 Deassertion of reset_n is assumed synchronous to clk by the system.

Structure
REQ-029 The shared package pc_lut_pkg shall hold:
- the state enum
- the tag constants TAG_REC=2'b10 and TAG_END=2'b11
- the localparams D and N.
REQ-030 The table storage shall be a single sub-module, pc_lut_ram: N×D flops, one synchronous write port, one combinational read port, async-clear reset.
REQ-031 The FSM and the framing checks shall reside in pc_lut_loader.

Verification
REQ-032 Load bytes 0x80, 0x00, 0x0B -> rd_addr=0 returns 11, wr_count=1.
REQ-033 Load 0x91, 0x0F, 0x71 (idx 17, off 0xF71) -> rd_addr=17 returns -143; rd_addr=18 returns 0.
REQ-034 Send 0x45 in IDLE -> err=1, state IDLE; a following valid record still writes correctly.
REQ-035 Send 0x82, 0x10 -> err=1; entry 2 unchanged; next byte parsed as B0.
REQ-036 Send 0xC0 -> loaded=1, in_ready=0; later 0x80, 0x00, 0x05 leave entry 0 unchanged.
REQ-037 Assert reset_n=0 after 0x83, 0x00 -> all entries 0, loaded=0; after release, 0x05 is parsed as B0 and flags err.
